// File: rtl/start_referee_if.sv
// Referee handshake bundle: generator/button inputs and round results.
// The bench or upstream logic drives the master side; the referee is the slave.
interface start_referee_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             rbit;
  logic             start;
  logic             btn_l;
  logic             btn_r;
  logic             busy;
  logic             go;
  logic             win_l;
  logic             win_r;
  logic             false_l;
  logic             false_r;
  logic             tie;
  logic             timeout;
  logic [CNT_W-1:0] react;

  modport master (
    output tick, rbit, start, btn_l, btn_r,
    input  busy, go, win_l, win_r,
    input  false_l, false_r, tie, timeout, react
  );

  modport slave (
    input  tick, rbit, start, btn_l, btn_r,
    output busy, go, win_l, win_r,
    output false_l, false_r, tie, timeout, react
  );
endinterface

// File: rtl/start_referee.sv
// Tug-of-war round referee: random start delay from the serial bit stream,
// then GO, then arbitration of false start / win / tie / timeout.
module start_referee #(
  parameter int SEED_BITS = 4,
  parameter int MIN_DELAY = 4,
  parameter int TIMEOUT   = 20,
  parameter int CNT_W     = 8
) (
  input  logic      clk,
  input  logic      rst,
  start_referee_if.slave bus
);
  localparam int BW = $clog2(SEED_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLL,
    S_WAIT,
    S_GO
  } state_t;

  state_t               state_q, state_d;
  logic [SEED_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     react_q, react_d;
  logic busy_q, busy_d;
  logic go_q, go_d;
  logic win_l_q, win_l_d;
  logic win_r_q, win_r_d;
  logic false_l_q, false_l_d;
  logic false_r_q, false_r_d;
  logic tie_q, tie_d;
  logic timeout_q, timeout_d;
  logic press;

  assign press = bus.btn_l | bus.btn_r;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    react_d   = react_q;
    win_l_d   = 1'b0;
    win_r_d   = 1'b0;
    false_l_d = 1'b0;
    false_r_d = 1'b0;
    tie_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COLL;
          shift_d = '0;
          bit_d   = '0;
          cnt_d   = '0;
          react_d = '0;
        end
      end
      S_COLL, S_WAIT: begin
        // A press beats a coincident tick: the count is left untouched.
        if (press) begin
          false_l_d = bus.btn_l;
          false_r_d = bus.btn_r;
          state_d   = S_IDLE;
        end else if (bus.tick) begin
          if (state_q == S_COLL) begin
            shift_d = {shift_q[SEED_BITS-2:0], bus.rbit};
            if (bit_q == BW'(SEED_BITS - 1)) begin
              state_d = S_WAIT;
              cnt_d   = CNT_W'(MIN_DELAY) + CNT_W'(shift_d);
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = S_GO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_GO: begin
        if (press) begin
          win_l_d = bus.btn_l & ~bus.btn_r;
          win_r_d = bus.btn_r & ~bus.btn_l;
          tie_d   = bus.btn_l & bus.btn_r;
          react_d = cnt_q;
          state_d = S_IDLE;
        end else if (bus.tick) begin
          if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
            react_d   = CNT_W'(TIMEOUT);
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    go_d   = (state_d == S_GO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      react_q   <= '0;
      busy_q    <= 1'b0;
      go_q      <= 1'b0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      false_l_q <= 1'b0;
      false_r_q <= 1'b0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      react_q   <= react_d;
      busy_q    <= busy_d;
      go_q      <= go_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      false_l_q <= false_l_d;
      false_r_q <= false_r_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.go      = go_q;
  assign bus.win_l   = win_l_q;
  assign bus.win_r   = win_r_q;
  assign bus.false_l = false_l_q;
  assign bus.false_r = false_r_q;
  assign bus.tie     = tie_q;
  assign bus.timeout = timeout_q;
  assign bus.react   = react_q;
endmodule

// File: tb/tb_start_referee.sv
// Directed bench for start_referee: delays, wins, tie, false starts,
// timeout, ignored starts/presses and asynchronous reset mid-round.
module tb_start_referee;
  localparam int CNT_W = 8;

  localparam logic [7:0] O_IDLE = 8'h00;
  localparam logic [7:0] O_BUSY = 8'h80;
  localparam logic [7:0] O_GO   = 8'hC0;
  localparam logic [7:0] O_WL   = 8'h20;
  localparam logic [7:0] O_WR   = 8'h10;
  localparam logic [7:0] O_FL   = 8'h08;
  localparam logic [7:0] O_FR   = 8'h04;
  localparam logic [7:0] O_TIE  = 8'h02;
  localparam logic [7:0] O_TO   = 8'h01;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  start_referee_if #(.CNT_W(CNT_W)) bus ();

  start_referee #(
    .SEED_BITS(4),
    .MIN_DELAY(4),
    .TIMEOUT(20),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.busy, bus.go, bus.win_l, bus.win_r,
            bus.false_l, bus.false_r, bus.tie, bus.timeout};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp_o,
                     input logic [CNT_W-1:0] exp_r);
    logic [7:0] o;
    o = outs();
    checks++;
    assert (o === exp_o && bus.react === exp_r)
    else begin
      errors++;
      $error("FAIL %s: outs=%b react=%0d, expected outs=%b react=%0d",
             tag, o, bus.react, exp_o, exp_r);
    end
  endtask

  // One clk with the given inputs; returns 1 ns after the edge.
  task automatic cyc(input logic t, input logic r, input logic s,
                     input logic bl, input logic br);
    bus.tick  = t;
    bus.rbit  = r;
    bus.start = s;
    bus.btn_l = bl;
    bus.btn_r = br;
    @(posedge clk);
    #1;
    bus.tick  = 1'b0;
    bus.rbit  = 1'b0;
    bus.start = 1'b0;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
  endtask

  task automatic ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, r, 1'b0, 1'b0, 1'b0);
  endtask

  // start, then four zero bits: WAIT with cnt=4
  task automatic round4();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.tick = 0; bus.rbit = 0; bus.start = 0;
    bus.btn_l = 0; bus.btn_r = 0;
    rst = 1'b1;
    #12;
    chk("reset", O_IDLE, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round 1: seed 1011 -> delay 15, right wins after 3 GO ticks
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_busy", O_BUSY, 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(14, 1'b0);
    chk("wait14_nogo", O_BUSY, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_notick", O_BUSY, 8'd0);
    ticks(1, 1'b0);
    chk("go_after15", O_GO, 8'd0);
    ticks(3, 1'b0);
    chk("go_3ticks", O_GO, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("win_r", O_WR, 8'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("win_r_pulse_end", O_IDLE, 8'd3);

    // Round 2: delay 4, tie at 0 ticks
    round4();
    ticks(3, 1'b0);
    chk("d4_nogo", O_BUSY, 8'd0);
    ticks(1, 1'b0);
    chk("d4_go", O_GO, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tie", O_TIE, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tie_end", O_IDLE, 8'd0);

    // Round 3: false start on a WAIT tick, then both in COLLECT
    round4();
    ticks(2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("false_l", O_FL, 8'd0);
    ticks(6, 1'b0);
    chk("false_l_nogo", O_IDLE, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("false_both", O_FL | O_FR, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("false_r_wait", O_FR, 8'd0);

    // Round 4: timeout on the 20th GO tick
    round4();
    ticks(4, 1'b0);
    ticks(19, 1'b0);
    chk("go_19", O_GO, 8'd0);
    ticks(1, 1'b0);
    chk("timeout", O_TO, 8'd20);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("timeout_end", O_IDLE, 8'd20);

    // Round 5: press on the timeout tick wins
    round4();
    chk("react_cleared", O_BUSY, 8'd0);
    ticks(4, 1'b0);
    ticks(19, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("win_l_over_to", O_WL, 8'd19);

    // Round 6: starts while busy are ignored; seed 0011 -> delay 7
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(6, 1'b0);
    chk("restart_nogo", O_BUSY, 8'd0);
    ticks(1, 1'b0);
    chk("restart_go", O_GO, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_in_go", O_GO, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("win_l_start", O_WL, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("end_start_ignored", O_IDLE, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_press", O_IDLE, 8'd0);

    // Round 7: async reset mid-WAIT, then a clean round
    round4();
    ticks(2, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", O_IDLE, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(6, 1'b0);
    chk("rst_no_result", O_IDLE, 8'd0);
    round4();
    ticks(4, 1'b0);
    chk("post_rst_go", O_GO, 8'd0);
    ticks(2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_win", O_WL, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/start_referee.md
Name: start_referee

Overview:
- Round-start referee for the tug-of-war game. It consumes the serial pseudo-random bit stream produced by the slow-enable-clocked random bit generator.
- It builds a random start delay from that stream, counts the delay down in slow ticks, then asserts GO.
- It arbitrates the two players' buttons: false start, win, tie or timeout. Results go to the rope/score logic downstream.

Parameters:
SEED_BITS, 4, number of random bits collected per round (>=2)
MIN_DELAY, 4, minimum start delay in ticks (>=1)
TIMEOUT, 20, ticks allowed after GO before the round is abandoned (>=1)
CNT_W, 8, counter width; must hold MIN_DELAY+2^SEED_BITS-1 and TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  slow enable, one clk cycle wide; the same strobe that advances the random generator
rbit  in  1  random bit from the generator; sampled on clk edges where tick=1
start  in  1  one-cycle round request pulse
btn_l  in  1  left player press, debounced, one-cycle pulse
btn_r  in  1  right player press, debounced, one-cycle pulse
busy  out  1  high in any state except IDLE
go  out  1  high while in GO
win_l, win_r  out  1  one-cycle result pulses
false_l, false_r  out  1  one-cycle false-start pulses
tie  out  1  one-cycle pulse on simultaneous presses during GO
timeout  out  1  one-cycle pulse when no press occurs within TIMEOUT ticks
react  out  CNT_W  ticks from GO to the winning press; held until next accepted start

Behaviour:
- Reset (async): state=IDLE. All outputs 0, react=0, internal shift/counters 0. Reset mid-round aborts with no result pulse.
- All outputs are registered; pulses last exactly one clk.
- IDLE:
  - start=1 -> COLLECT; clear shift and bit count; clear react.
  - Buttons in IDLE are ignored.
- COLLECT:
  - Each tick: shift <= {shift[SEED_BITS-2:0], rbit}; bitcnt++.
  - On the SEED_BITS-th tick -> WAIT; load cnt = MIN_DELAY + new shift value, zero-extended to CNT_W.
- WAIT:
  - Each tick: if cnt==1 -> GO and clear cnt; else cnt--.
  - GO therefore rises the clk after the Nth WAIT tick, where N = loaded cnt.
- False start (COLLECT or WAIT):
  - btn_l -> false_l pulse, -> IDLE.
  - btn_r -> false_r pulse, -> IDLE.
  - Both in same cycle -> both pulses, -> IDLE.
  - Button has priority over a simultaneous tick.
- GO:
  - go=1; cnt increments on each tick.
  - btn_l only -> win_l, react=cnt, -> IDLE.
  - btn_r only -> win_r, react=cnt, -> IDLE.
  - Both -> tie, react=cnt, -> IDLE.
  - If a tick brings cnt to TIMEOUT with no press in the same cycle -> timeout pulse, react=TIMEOUT, -> IDLE. A press in the same cycle wins over the timeout.
  - go deasserts in the same cycle the result pulse asserts.
- start while busy is ignored. A start in the same cycle a round ends is also ignored; a new round needs start in IDLE.
- Exactly one of {win_l, win_r, tie, timeout, false_l|false_r} fires per started round.

Test Plan:
- Defaults; start; rbit=1,0,1,1 on four ticks -> shift=1011 (11), cnt=15. go rises the clk after the 15th WAIT tick. btn_r after 3 GO ticks -> win_r pulse, react=3, busy=0.
- rbit=0,0,0,0 -> delay 4 ticks. btn_l and btn_r in same cycle during GO after 0 ticks -> tie=1 for one clk, react=0, no win pulses.
- btn_l during WAIT coinciding with a tick -> false_l pulse, go never asserts, IDLE next cycle, cnt not decremented.
- Round reaches GO, no presses for 20 ticks -> timeout pulse on the 20th tick, react=20. btn_l on that same tick instead -> win_l, no timeout.
- start pulses during COLLECT/WAIT/GO -> no restart, bit count unaffected. Presses in IDLE -> no output pulses.
- rst asserted mid-WAIT between clk edges -> outputs 0 immediately, state IDLE, no result pulse after release. The next start completes a full round normally.
